// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers VGA geometry, pixel col/row and lock state from sync/disp_ena.
module vga_sync_decoder #(
  parameter bit h_pol       = 1'b1,
  parameter bit v_pol       = 1'b1,
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             h_sync,
  input  logic             v_sync,
  input  logic             disp_ena,
  output logic             pix_valid,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic             locked,
  output logic             frame_start
);
  localparam logic [1:0] SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2;
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] LF = CNT_W'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic hs_a, vs_a, de_s, hs_p, vs_p, de_p;
  logic h_lead, v_lead, de_rise, de_fall, tuple_eq, h_bad;
  logic [CNT_W-1:0] h_cnt, line_len, line_cnt, act_cnt, act_len, row_cnt, match_cnt;
  logic [CNT_W-1:0] line_len_n, act_len_n, match_n;
  logic [1:0] state, state_n;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] x);
    return (x == MAX) ? x : x + ONE;
  endfunction

  assign h_lead     = hs_a & ~hs_p;
  assign v_lead     = vs_a & ~vs_p;
  assign de_rise    = de_s & ~de_p;
  assign de_fall    = ~de_s & de_p;
  assign line_len_n = h_lead ? inc(h_cnt) : line_len;
  assign act_len_n  = de_fall ? act_cnt : act_len;
  assign tuple_eq   = {line_len_n, line_cnt, act_len_n, row_cnt} == {h_total, v_total, h_active, v_active};
  // a stalled source shows up as h_cnt pinned at its ceiling
  assign h_bad      = (h_lead && line_len_n != h_total) || h_cnt == MAX;
  assign match_n    = (match_cnt != '0 && tuple_eq) ? inc(match_cnt) : ONE;
  assign locked     = state == LOCKED;

  always_comb begin
    state_n = state == SEARCH  ? (v_lead ? MEASURE : SEARCH) :
              state == MEASURE ? ((v_lead && match_n == LF) ? LOCKED : MEASURE) :
              ((h_bad || (v_lead && !tuple_eq)) ? SEARCH : LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {hs_a, vs_a, de_s, hs_p, vs_p, de_p} <= '0;
      h_cnt       <= '0;
      line_len    <= '0;
      line_cnt    <= '0;
      act_cnt     <= '0;
      act_len     <= '0;
      row_cnt     <= '0;
      match_cnt   <= '0;
      state       <= SEARCH;
      pix_valid   <= 1'b0;
      col         <= '0;
      row         <= '0;
      h_total     <= '0;
      v_total     <= '0;
      h_active    <= '0;
      v_active    <= '0;
      frame_start <= 1'b0;
    end else begin
      hs_a        <= h_sync == h_pol;
      vs_a        <= v_sync == v_pol;
      de_s        <= disp_ena;
      hs_p        <= hs_a;
      vs_p        <= vs_a;
      de_p        <= de_s;
      h_cnt       <= h_lead ? '0 : inc(h_cnt);
      line_len    <= line_len_n;
      line_cnt    <= v_lead ? CNT_W'(h_lead) : h_lead ? inc(line_cnt) : line_cnt;
      act_cnt     <= de_rise ? ONE : de_s ? inc(act_cnt) : act_cnt;
      act_len     <= act_len_n;
      row_cnt     <= v_lead ? '0 : de_fall ? inc(row_cnt) : row_cnt;
      pix_valid   <= de_s;
      col         <= de_rise ? '0 : de_s ? inc(col) : col;
      row         <= de_s ? row_cnt : row;
      h_total     <= v_lead ? line_len_n : h_total;
      v_total     <= v_lead ? line_cnt : v_total;
      h_active    <= v_lead ? act_len_n : h_active;
      v_active    <= v_lead ? row_cnt : v_active;
      frame_start <= v_lead;
      state       <= state_n;
      match_cnt   <= (state == MEASURE && v_lead) ? match_n :
                     (state == SEARCH || state_n == SEARCH) ? '0 : match_cnt;
    end
  end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: frame-table driven checks on a scaled-down VGA stream, both sync polarities.
module tb_vga_sync_decoder;
  localparam int W = 12, HT = 40, HS = 4, HX0 = 10, HA = 24, VT = 20, VS = 2, VY0 = 5, VA = 12;

  typedef struct {
    int short_ln;
    int rst_ln;
    bit exp_lk;
    bit meas;
    bit pix;
  } frame_t;

  logic clk = 1'b0, rst = 1'b1, hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic pv[2], lk[2], fs[2];
  logic [W-1:0] col[2], row[2], ht[2], vt[2], ha[2], va[2];
  int checks = 0, errors = 0;
  bit lk_exp = 1'b0;
  frame_t tbl[15];

  always #5 clk = ~clk;

  vga_sync_decoder #(.h_pol(1'b1), .v_pol(1'b1), .CNT_W(W), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .h_sync(hs), .v_sync(vs), .disp_ena(de),
    .pix_valid(pv[0]), .col(col[0]), .row(row[0]), .h_total(ht[0]), .v_total(vt[0]),
    .h_active(ha[0]), .v_active(va[0]), .locked(lk[0]), .frame_start(fs[0]));

  vga_sync_decoder #(.h_pol(1'b0), .v_pol(1'b0), .CNT_W(W), .LOCK_FRAMES(2)) dut_n (
    .clk(clk), .rst(rst), .h_sync(~hs), .v_sync(~vs), .disp_ena(de),
    .pix_valid(pv[1]), .col(col[1]), .row(row[1]), .h_total(ht[1]), .v_total(vt[1]),
    .h_active(ha[1]), .v_active(va[1]), .locked(lk[1]), .frame_start(fs[1]));

  task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d]: got %0d expected %0d", nm, d, got, exp);
    end
  endtask

  task automatic drive(input bit h, input bit v, input bit d, input bit r);
    hs = h; vs = v; de = d; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic zero_chk(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_pv"}, d, pv[d], 0);
      chk({tag, "_col"}, d, col[d], 0);
      chk({tag, "_row"}, d, row[d], 0);
      chk({tag, "_ht"}, d, ht[d], 0);
      chk({tag, "_vt"}, d, vt[d], 0);
      chk({tag, "_ha"}, d, ha[d], 0);
      chk({tag, "_va"}, d, va[d], 0);
      chk({tag, "_lk"}, d, lk[d], 0);
      chk({tag, "_fs"}, d, fs[d], 0);
    end
  endtask

  // each sample reflects the edge that captured the current slot; pixel outputs lag one more slot
  task automatic run_frame(input frame_t f);
    int fsc[2];
    fsc[0] = 0;
    fsc[1] = 0;
    for (int y = 0; y < VT; y++) begin
      int len;
      len = (y == f.short_ln) ? HT - 2 : HT;
      for (int x = 0; x < len; x++) begin
        bit r;
        r = (y == f.rst_ln) && (x == 5);
        drive(x < HS, y < VS, (y >= VY0) && (y < VY0 + VA) && (x >= HX0) && (x < HX0 + HA), r);
        if (r) zero_chk("mid_reset");
        for (int d = 0; d < 2; d++) begin
          if (fs[d]) fsc[d]++;
          if (y == 0 && x == 0) chk("lock_before_vlead", d, lk[d], lk_exp);
          if (y == 0 && x == 1) begin
            chk("lock_after_vlead", d, lk[d], f.exp_lk);
            chk("frame_start", d, fs[d], 1);
            if (f.meas) begin
              chk("h_total", d, ht[d], HT);
              chk("v_total", d, vt[d], VT);
              chk("h_active", d, ha[d], HA);
              chk("v_active", d, va[d], VA);
            end
          end
          if (f.short_ln >= 0 && y == f.short_ln + 1 && x < 2)
            chk("short_line_unlock", d, lk[d], x == 0);
          if (f.pix) begin
            if (y == VY0 && x == HX0) chk("pv_latency", d, pv[d], 0);
            if (y == VY0 && x == HX0 + 1) begin
              chk("first_pv", d, pv[d], 1);
              chk("first_col", d, col[d], 0);
              chk("first_row", d, row[d], 0);
            end
            if (y == VY0 + 3 && x == HX0 + 8) begin
              chk("mid_col", d, col[d], 7);
              chk("mid_row", d, row[d], 3);
            end
            if (y == VY0 + VA - 1 && x == HX0 + HA) begin
              chk("last_pv", d, pv[d], 1);
              chk("last_col", d, col[d], HA - 1);
              chk("last_row", d, row[d], VA - 1);
            end
            if (y == VY0 + VA - 1 && x == HX0 + HA + 1) chk("pv_end", d, pv[d], 0);
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) chk("frame_start_count", d, fsc[d], 1);
    lk_exp = f.exp_lk && f.short_ln < 0 && f.rst_ln < 0;
  endtask

  initial begin
    int n;
    tbl[0]  = '{-1, -1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{-1, -1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{-1, -1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{-1, -1, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{ 7, -1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{-1, -1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{-1, -1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{-1, -1, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{-1, -1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{-1, -1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{-1, -1, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{-1,  8, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{-1, -1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{-1, -1, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{-1, -1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
    zero_chk("reset");
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) run_frame(tbl[i]);
    // syncs go quiet while locked: h_cnt must hit its ceiling and drop lock
    n = 0;
    while ((lk[0] || lk[1]) && n < 4095) begin
      drive(0, 0, 0, 0);
      n++;
    end
    for (int d = 0; d < 2; d++) begin
      chk("idle_unlock", d, lk[d], 0);
      chk("idle_h_total_held", d, ht[d], HT);
    end
    chk("idle_unlock_time", 0, (n >= 4050 && n <= 4095), 1);
    lk_exp = 1'b0;
    for (int i = 8; i < 15; i++) run_frame(tbl[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
